pipeline_mem_stage: RTL and testbench
=====================================

Name: pipeline_mem_stage

Overview:
Memory stage of the 5-stage pipelined MIPS core. It consumes the EX/MEM latch outputs and issues data-memory reads and writes with a hit/wait handshake. It stalls the upstream stages until the access completes, then drives the MEM/WB latch feeding writeback. It also owns the sticky halt propagation and a stall-cycle performance counter.

Parameters:
WORD_W, 32, data/address width (word_t)
REG_W, 5, register select width (regbits_t)
CNT_W, 32, width of the stall-cycle counter

Ports:
CLK  in  1  core clock, all state updates on rising edge
sRST  in  1  synchronous active-high reset
in_valid  in  1  EX/MEM latch holds a live instruction
in_porto  in  WORD_W  ALU result; memory address for loads/stores
in_rdat2  in  WORD_W  store data
in_wsel  in  REG_W  destination register
in_regen  in  1  register write enable
in_regsrc  in  2  writeback source select, passed through
in_hlt  in  1  halt instruction
in_dmemREN  in  1  load
in_dmemWEN  in  1  store
flush  in  1  squash the instruction currently in this stage
dhit  in  1  data memory access complete this cycle
dmemload  in  WORD_W  read data, valid when dhit=1
dmemREN  out  1  read request
dmemWEN  out  1  write request
dmemaddr  out  WORD_W  request address
dmemstore  out  WORD_W  store data
stall  out  1  hold EX/MEM and all upstream latches
wb_valid  out  1  MEM/WB holds a live instruction
wb_porto  out  WORD_W  latched ALU result
wb_dmemload  out  WORD_W  latched load data
wb_wsel  out  REG_W  latched destination register
wb_regen  out  1  latched write enable, gated by wb_valid
wb_regsrc  out  2  latched writeback source select
wb_hlt  out  1  sticky halt to writeback/system
stall_cnt  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Interface: one clock, CLK; reset sRST is synchronous and active-high.
- Reset: state=IDLE. All wb_* = 0, dmemREN=dmemWEN=0, dmemaddr=dmemstore=0, stall=0, stall_cnt=0, flush-pending=0. sRST overrides every other input, including while in ACCESS; any outstanding request is dropped.
- FSM states:
  - IDLE: in_valid and (in_dmemREN or in_dmemWEN) and not flush -> capture addr, store data, REN, WEN, and control into request registers; go to ACCESS; stall=1 combinationally this cycle.
  - IDLE: in_valid, no memory op, not in_hlt -> MEM/WB loads next edge with wb_valid=1, wb_dmemload=0; 1-cycle latency; no stall.
  - IDLE: in_valid and in_hlt -> wb_hlt=1, wb_valid=1, go to HALTED.
  - IDLE: flush=1 -> next edge wb_valid=0 and wb_regen=0; no request issued.
  - ACCESS: dmemREN/dmemWEN/dmemaddr/dmemstore are driven from the request registers, so they are stable for the whole access. stall = not dhit.
  - ACCESS, on the dhit cycle -> MEM/WB loads captured control plus dmemload (loads) or 0 (stores); wb_valid=1; return to IDLE; requests drop to 0 next cycle.
  - HALTED: stall=1, no requests, MEM/WB frozen; exit only via sRST.
- Flush during ACCESS: does not abort the memory transaction. It sets flush-pending; on completion wb_valid=0, wb_regen=0; flush-pending then clears.
- If both dmemREN and dmemWEN are asserted, the write takes priority: a write is issued and no load data is latched.
- stall_cnt increments every cycle stall=1 and saturates at all ones; it never wraps.
- When stall=0 and in_valid=0 (bubble), wb_valid=0 next edge and the other wb_* fields hold.

Test Plan:
- Reset mid-access: start a load, assert sRST before dhit -> next cycle dmemREN=0, state IDLE, wb_valid=0, stall_cnt=0.
- ALU op: in_porto=0x0000_00AA, wsel=5, regen=1 -> next cycle wb_valid=1, wb_porto=0xAA, wb_wsel=5, stall=0 throughout.
- Load, 3-cycle wait: in_porto=0x100, REN=1; dhit on the 3rd ACCESS cycle with dmemload=0xDEADBEEF -> dmemaddr=0x100 steady, stall=1 for 3 cycles, then wb_dmemload=0xDEADBEEF, wb_valid=1, stall_cnt=3.
- Store: addr=0x40, rdat2=0x1234, dhit on first ACCESS cycle -> dmemWEN=1 for exactly 1 cycle, dmemstore=0x1234, wb_regen=0.
- Flush during load: flush=1 in 2nd ACCESS cycle, dhit later -> request completes, then wb_valid=0, wb_regen=0.
- Halt, then stall saturation: halt instruction -> wb_hlt=1 sticky, stall=1 permanently. With CNT_W=4, stall_cnt stops at 15.

Source files
------------

// File: rtl/pipeline_mem_stage.sv
// pipeline_mem_stage: memory stage of the 5-stage MIPS pipeline.
//   Takes the EX/MEM latch, issues data-memory reads/writes with a dhit
//   handshake, stalls upstream until the access completes, and drives the
//   MEM/WB latch. Also owns sticky halt and a saturating stall-cycle counter.
// Ports:
//   CLK, sRST             clock, synchronous active-high reset
//   in_*                  EX/MEM latch contents
//   flush                 squash the instruction in this stage
//   dhit, dmemload        memory completion and read data
//   dmemREN/WEN/addr/store memory request, held stable for the whole access
//   stall                 hold EX/MEM and everything upstream
//   wb_*                  MEM/WB latch contents, wb_hlt sticky
//   stall_cnt             saturating count of stalled cycles
module pipeline_mem_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              sRST,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_porto,
    input  logic [WORD_W-1:0] in_rdat2,
    input  logic [REG_W-1:0]  in_wsel,
    input  logic              in_regen,
    input  logic [1:0]        in_regsrc,
    input  logic              in_hlt,
    input  logic              in_dmemREN,
    input  logic              in_dmemWEN,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              stall,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_porto,
    output logic [WORD_W-1:0] wb_dmemload,
    output logic [REG_W-1:0]  wb_wsel,
    output logic              wb_regen,
    output logic [1:0]        wb_regsrc,
    output logic              wb_hlt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_t;

    state_t            state;
    logic              req_ren, req_wen;
    logic [WORD_W-1:0] req_addr, req_store;
    logic [REG_W-1:0]  req_wsel;
    logic              req_regen;
    logic [1:0]        req_regsrc;
    logic              flush_pend;
    logic              wb_regen_q;
    logic              mem_op;
    logic              squash;

    assign mem_op = in_valid & (in_dmemREN | in_dmemWEN);
    // A flush seen at any point of the access (including its final cycle)
    // kills the writeback but never the memory transaction itself.
    assign squash = flush_pend | flush;

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = mem_op & ~flush;
            ACCESS:  stall = ~dhit;
            HALTED:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Request lines come straight from the capture registers so the memory
    // sees a constant request for the whole access.
    assign dmemREN   = (state == ACCESS) & req_ren;
    assign dmemWEN   = (state == ACCESS) & req_wen;
    assign dmemaddr  = (state == ACCESS) ? req_addr  : '0;
    assign dmemstore = (state == ACCESS) ? req_store : '0;
    assign wb_regen  = wb_regen_q & wb_valid;

    always_ff @(posedge CLK) begin
        if (sRST) begin
            state       <= IDLE;
            req_ren     <= 1'b0;
            req_wen     <= 1'b0;
            req_addr    <= '0;
            req_store   <= '0;
            req_wsel    <= '0;
            req_regen   <= 1'b0;
            req_regsrc  <= '0;
            flush_pend  <= 1'b0;
            wb_valid    <= 1'b0;
            wb_porto    <= '0;
            wb_dmemload <= '0;
            wb_wsel     <= '0;
            wb_regen_q  <= 1'b0;
            wb_regsrc   <= '0;
            wb_hlt      <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (flush) begin
                        wb_valid   <= 1'b0;
                        wb_regen_q <= 1'b0;
                    end else if (mem_op) begin
                        // write wins when both are set: no load data latched
                        req_ren    <= in_dmemREN & ~in_dmemWEN;
                        req_wen    <= in_dmemWEN;
                        req_addr   <= in_porto;
                        req_store  <= in_rdat2;
                        req_wsel   <= in_wsel;
                        req_regen  <= in_regen;
                        req_regsrc <= in_regsrc;
                        flush_pend <= 1'b0;
                        wb_valid   <= 1'b0;
                        state      <= ACCESS;
                    end else if (in_valid) begin
                        wb_valid    <= 1'b1;
                        wb_porto    <= in_porto;
                        wb_dmemload <= '0;
                        wb_wsel     <= in_wsel;
                        wb_regen_q  <= in_regen;
                        wb_regsrc   <= in_regsrc;
                        if (in_hlt) begin
                            wb_hlt <= 1'b1;
                            state  <= HALTED;
                        end
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (flush)
                        flush_pend <= 1'b1;
                    if (dhit) begin
                        wb_valid    <= ~squash;
                        wb_porto    <= req_addr;
                        wb_dmemload <= req_ren ? dmemload : '0;
                        wb_wsel     <= req_wsel;
                        wb_regen_q  <= req_regen & ~squash;
                        wb_regsrc   <= req_regsrc;
                        req_ren     <= 1'b0;
                        req_wen     <= 1'b0;
                        flush_pend  <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                HALTED: begin
                    // frozen until reset
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
module tb_pipeline_mem_stage;
    localparam int WW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          sRST = 1'b1;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_porto = '0, in_rdat2 = '0;
    logic [RW-1:0] in_wsel = '0;
    logic          in_regen = 1'b0;
    logic [1:0]    in_regsrc = '0;
    logic          in_hlt = 1'b0, in_dmemREN = 1'b0, in_dmemWEN = 1'b0;
    logic          flush = 1'b0, dhit = 1'b0;
    logic [WW-1:0] dmemload = '0;
    logic          dmemREN, dmemWEN, stall, wb_valid, wb_regen, wb_hlt;
    logic [WW-1:0] dmemaddr, dmemstore, wb_porto, wb_dmemload;
    logic [RW-1:0] wb_wsel;
    logic [1:0]    wb_regsrc;
    logic [CW-1:0] stall_cnt;

    pipeline_mem_stage #(.WORD_W(WW), .REG_W(RW), .CNT_W(CW)) dut (
        .CLK(CLK), .sRST(sRST), .in_valid(in_valid), .in_porto(in_porto),
        .in_rdat2(in_rdat2), .in_wsel(in_wsel), .in_regen(in_regen),
        .in_regsrc(in_regsrc), .in_hlt(in_hlt), .in_dmemREN(in_dmemREN),
        .in_dmemWEN(in_dmemWEN), .flush(flush), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .stall(stall), .wb_valid(wb_valid),
        .wb_porto(wb_porto), .wb_dmemload(wb_dmemload), .wb_wsel(wb_wsel),
        .wb_regen(wb_regen), .wb_regsrc(wb_regsrc), .wb_hlt(wb_hlt),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WW-1:0] porto;
        logic [WW-1:0] dload;
        logic [RW-1:0] wsel;
        logic          regen;
        logic [1:0]    regsrc;
        logic          hlt;
    } wb_t;

    typedef struct {
        logic [WW-1:0] addr;
        logic [WW-1:0] sdata;
        logic          ren;
        logic          wen;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    int   total = 0;
    int   bad = 0;
    int   ref_cnt = 0;
    logic exp_stall = 1'b0;
    bit   halted_seen = 1'b0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge CLK) begin
        if (sRST) begin
            ref_cnt = 0;
        end else begin
            chk("stall", {31'b0, stall}, {31'b0, exp_stall});
            chk("stall_cnt", {28'b0, stall_cnt}, ref_cnt);
            if (stall && ref_cnt < CNT_MAX) ref_cnt++;

            if (dmemREN || dmemWEN) begin
                total++;
                if (req_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_request: got REN=%0b WEN=%0b expected none", dmemREN, dmemWEN);
                end else begin
                    total--;
                    chk("dmemaddr", dmemaddr, req_q[0].addr);
                    chk("dmemREN", {31'b0, dmemREN}, {31'b0, req_q[0].ren});
                    chk("dmemWEN", {31'b0, dmemWEN}, {31'b0, req_q[0].wen});
                    if (req_q[0].wen) chk("dmemstore", dmemstore, req_q[0].sdata);
                    if (dhit) void'(req_q.pop_front());
                end
            end

            if (wb_valid && !halted_seen) begin
                total++;
                if (wb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_wb: got wb_valid=1 porto=%h expected no result", wb_porto);
                end else begin
                    wb_t e;
                    total--;
                    e = wb_q.pop_front();
                    chk("wb_hlt", {31'b0, wb_hlt}, {31'b0, e.hlt});
                    if (e.hlt) begin
                        halted_seen = 1'b1;
                    end else begin
                        chk("wb_porto", wb_porto, e.porto);
                        chk("wb_dmemload", wb_dmemload, e.dload);
                        chk("wb_wsel", {27'b0, wb_wsel}, {27'b0, e.wsel});
                        chk("wb_regen", {31'b0, wb_regen}, {31'b0, e.regen});
                        chk("wb_regsrc", {30'b0, wb_regsrc}, {30'b0, e.regsrc});
                    end
                end
            end
            if (!wb_valid) chk("wb_regen_gated", {31'b0, wb_regen}, 0);
            if (halted_seen) chk("wb_hlt_sticky", {31'b0, wb_hlt}, 1);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
        dhit  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic set_instr(input logic [WW-1:0] porto, input logic [WW-1:0] rdat2,
                             input logic [RW-1:0] wsel, input logic regen,
                             input logic [1:0] regsrc, input logic hlt,
                             input logic ren, input logic wen);
        in_valid = 1'b1; in_porto = porto; in_rdat2 = rdat2; in_wsel = wsel;
        in_regen = regen; in_regsrc = regsrc; in_hlt = hlt;
        in_dmemREN = ren; in_dmemWEN = wen;
    endtask

    task automatic do_alu(input logic [WW-1:0] porto, input logic [RW-1:0] wsel,
                          input logic regen, input logic [1:0] regsrc);
        cyc();
        set_instr(porto, $urandom, wsel, regen, regsrc, 1'b0, 1'b0, 1'b0);
        exp_stall = 1'b0;
        wb_q.push_back('{porto, '0, wsel, regen, regsrc, 1'b0});
    endtask

    task automatic do_bubble();
        cyc();
        in_valid = 1'b0;
        in_porto = $urandom;
        exp_stall = 1'b0;
    endtask

    task automatic do_flush_idle();
        cyc();
        set_instr($urandom, $urandom, 5'($urandom), 1'b1, 2'($urandom), 1'b0,
                  1'($urandom), 1'($urandom));
        flush = 1'b1;
        exp_stall = 1'b0;
    endtask

    // lat = ACCESS cycle carrying dhit; fcyc = ACCESS cycle carrying flush (0 = none)
    task automatic do_mem(input logic [WW-1:0] addr, input logic [WW-1:0] sdata,
                          input logic ren, input logic wen, input logic [RW-1:0] wsel,
                          input logic regen, input logic [1:0] regsrc,
                          input int lat, input int fcyc, input logic [WW-1:0] ldata);
        cyc();
        set_instr(addr, sdata, wsel, regen, regsrc, 1'b0, ren, wen);
        exp_stall = 1'b1;
        req_q.push_back('{addr, sdata, ren & ~wen, wen});
        if (fcyc == 0)
            wb_q.push_back('{addr, (ren && !wen) ? ldata : '0, wsel, regen, regsrc, 1'b0});
        for (int k = 1; k <= lat; k++) begin
            cyc();
            dhit      = (k == lat);
            dmemload  = (k == lat) ? ldata : $urandom;
            flush     = (k == fcyc);
            exp_stall = (k != lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        sRST = 1'b0;
        chk("rst_dmemREN", {31'b0, dmemREN}, 0);
        chk("rst_dmemWEN", {31'b0, dmemWEN}, 0);
        chk("rst_dmemaddr", dmemaddr, 0);
        chk("rst_dmemstore", dmemstore, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 0);
        chk("rst_wb_hlt", {31'b0, wb_hlt}, 0);
        chk("rst_stall_cnt", {28'b0, stall_cnt}, 0);

        // directed cases
        do_alu(32'h0000_00AA, 5'd5, 1'b1, 2'd0);
        do_mem(32'h100, 32'h0, 1'b1, 1'b0, 5'd7, 1'b1, 2'd1, 3, 0, 32'hDEADBEEF);
        do_bubble();
        do_mem(32'h40, 32'h1234, 1'b0, 1'b1, 5'd0, 1'b0, 2'd0, 1, 0, 32'h0);
        do_mem(32'h200, 32'h0, 1'b1, 1'b0, 5'd3, 1'b1, 2'd1, 4, 2, 32'h5555_AAAA);
        do_mem(32'h80, 32'h9999, 1'b1, 1'b1, 5'd9, 1'b1, 2'd2, 2, 0, 32'hFFFF_0000);
        do_alu(32'h0000_0777, 5'd12, 1'b1, 2'd3);

        // reset in the middle of a load
        cyc();
        set_instr(32'h300, 32'h0, 5'd4, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        exp_stall = 1'b1;
        req_q.push_back('{32'h300, 32'h0, 1'b1, 1'b0});
        wb_q.push_back('{32'h300, 32'h0, 5'd4, 1'b1, 2'd1, 1'b0});
        cyc();
        exp_stall = 1'b1;
        cyc();
        sRST = 1'b1;
        in_valid = 1'b0;
        req_q.delete();
        wb_q.delete();
        cyc();
        sRST = 1'b0;
        exp_stall = 1'b0;
        chk("midrst_dmemREN", {31'b0, dmemREN}, 0);
        chk("midrst_wb_valid", {31'b0, wb_valid}, 0);
        chk("midrst_stall_cnt", {28'b0, stall_cnt}, 0);
        chk("midrst_stall", {31'b0, stall}, 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                do_alu($urandom, 5'($urandom), 1'($urandom), 2'($urandom));
            end else if (r == 3) begin
                do_bubble();
            end else if (r == 4) begin
                do_flush_idle();
            end else begin
                int lat, fc, op;
                logic ren, wen;
                lat = $urandom_range(1, 4);
                op  = $urandom_range(0, 6);
                ren = (op <= 3) || (op == 6);
                wen = (op >= 4);
                fc  = (lat > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, lat - 1) : 0;
                do_mem($urandom, $urandom, ren, wen, 5'($urandom), 1'($urandom),
                       2'($urandom), lat, fc, $urandom);
            end
        end

        // halt: sticky, stall forever, counter saturates
        cyc();
        set_instr(32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        exp_stall = 1'b0;
        wb_q.push_back('{32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b1});
        for (int n = 0; n < 25; n++) begin
            cyc();
            set_instr($urandom, $urandom, 5'($urandom), 1'($urandom), 2'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom));
            in_valid = 1'($urandom);
            dhit = 1'($urandom);
            exp_stall = 1'b1;
        end
        cyc();
        exp_stall = 1'b1;
        chk("halt_wb_hlt", {31'b0, wb_hlt}, 1);
        chk("halt_stall_cnt_sat", {28'b0, stall_cnt}, CNT_MAX);
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("req_queue_drained", req_q.size(), 0);
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
